// File: rtl/video_axis_pkg.sv
// Shared types and helpers for the AXI-Stream video frame source.
package video_axis_pkg;

  localparam int TLAST_EOF  = 0;
  localparam int TLAST_EOL  = 1;
  localparam int PIX_DATA_W = 24;

  typedef struct packed {
    logic [PIX_DATA_W-1:0] data;
    logic                  user;
    logic                  last;
  } pix_beat_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } src_state_e;

  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/axis_frame_source_if.sv
// AXI-Stream pixel channel between the frame source and its downstream sink.
interface axis_frame_source_if
  import video_axis_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_DATA_W
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry output skid: the head entry drives the stream directly, so valid and
// data come straight from flops. The parent keeps pushes within the reported occupancy.
module axis_skid_buffer #(
  parameter int BEAT_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] in_beat,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_beat,
  input  logic              out_ready,
  output logic [1:0]        occ
);

  logic [BEAT_W-1:0] head_q, head_d;
  logic [BEAT_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;
  logic              pop;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise latches appear.
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    pop    = (occ_q != 2'd0) && out_ready;
    case (occ_q)
      2'd0: begin
        if (in_valid) begin
          head_d = in_beat;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (in_valid && pop) begin
          head_d = in_beat;
        end else if (in_valid) begin
          tail_d = in_beat;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (in_valid) tail_d = in_beat;
          else          occ_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked blocks use non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      // NOTE: storage is reset too, because the head entry is tdata and must read 0 out of reset.
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_beat  = head_q;
  assign occ       = occ_q;

endmodule

// File: rtl/axis_frame_source.sv
// Streams one WIDTH x HEIGHT frame from a 1-cycle-latency frame buffer onto AXI-Stream,
// with tuser on the first pixel and tlast on end of frame or end of line.
module axis_frame_source
  import video_axis_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 100,
  parameter int DATA_WIDTH = PIX_DATA_W,
  parameter int TLAST_MODE = TLAST_EOF,
  parameter int ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  axis_frame_source_if.master   m_axis
);

  localparam int N     = frame_pixels(WIDTH, HEIGHT);
  localparam int CNT_W = ADDR_W + 1;
  localparam int XW    = $clog2(WIDTH + 1);
  localparam int YW    = $clog2(HEIGHT + 1);

  localparam logic [CNT_W-1:0] N_C    = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N - 1);
  localparam logic [XW-1:0]    X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]    Y_LAST = YW'(HEIGHT - 1);

  src_state_e       state_q, state_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             inflight_q, inflight_d;
  logic             side_user_q, side_user_d;
  logic             side_last_q, side_last_d;

  logic             pop;
  logic [1:0]       occ;
  logic [1:0]       fill;
  logic             rd_user, rd_last;
  logic             skid_valid;
  pix_beat_t        push_beat, out_beat;

  // Skid entries plus the read still in the RAM pipeline; reads stop before this exceeds two.
  assign fill = occ + {1'b0, inflight_q};
  assign pop  = skid_valid & m_axis.tready;

  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    out_cnt_d     = out_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    side_user_d   = side_user_q;
    side_last_d   = side_last_q;
    mem_rd_en     = 1'b0;
    done          = 1'b0;

    rd_user = (rd_cnt_q == '0);
    if (TLAST_MODE == TLAST_EOL) rd_last = (x_q == X_LAST);
    else                         rd_last = (x_q == X_LAST) && (y_q == Y_LAST);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          x_d       = '0;
          y_d       = '0;
        end
      end
      ST_RUN: begin
        if ((rd_cnt_q < N_C) && ((fill < 2'd2) || ((fill == 2'd2) && pop))) begin
          mem_rd_en   = 1'b1;
          rd_cnt_d    = rd_cnt_q + CNT_W'(1);
          side_user_d = rd_user;
          side_last_d = rd_last;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
        if (pop) begin
          if (out_cnt_q == LAST_C) begin
            done          = 1'b1;
            state_d       = ST_IDLE;
            frame_count_d = frame_count_q + 16'd1;
          end else begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    inflight_d = mem_rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rd_cnt_q      <= '0;
      out_cnt_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= 16'd0;
      inflight_q    <= 1'b0;
      side_user_q   <= 1'b0;
      side_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      out_cnt_q     <= out_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      inflight_q    <= inflight_d;
      side_user_q   <= side_user_d;
      side_last_q   <= side_last_d;
    end
  end

  // Sideband captured at read issue rejoins its pixel when the RAM returns it.
  assign push_beat = '{data: mem_rd_data, user: side_user_q, last: side_last_q};

  axis_skid_buffer #(
    .BEAT_W($bits(pix_beat_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_beat   (push_beat),
    .out_valid (skid_valid),
    .out_beat  (out_beat),
    .out_ready (m_axis.tready),
    .occ       (occ)
  );

  assign m_axis.tvalid = skid_valid;
  assign m_axis.tdata  = out_beat.data;
  assign m_axis.tuser  = out_beat.user;
  assign m_axis.tlast  = out_beat.last;

  assign busy        = (state_q == ST_RUN);
  assign mem_addr    = rd_cnt_q[ADDR_W-1:0];
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Scoreboard bench: two 4x2 sources (end-of-frame and end-of-line tlast) share stimulus,
// and a 128x100 source streams a full frame under random backpressure.
module tb_axis_frame_source;

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_s, start_c, tready_s, tready_c;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   got;

  exp_t exp_q [3][$];

  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [15:0] fc_a, fc_b, fc_c;
  logic        re_a, re_b, re_c;
  logic [2:0]  addr_a, addr_b;
  logic [13:0] addr_c;
  logic [23:0] rd_a, rd_b, rd_c;

  axis_frame_source_if #(.DATA_WIDTH(24)) if_a ();
  axis_frame_source_if #(.DATA_WIDTH(24)) if_b ();
  axis_frame_source_if #(.DATA_WIDTH(24)) if_c ();

  assign if_a.tready = tready_s;
  assign if_b.tready = tready_s;
  assign if_c.tready = tready_c;

  axis_frame_source #(.WIDTH(4), .HEIGHT(2), .DATA_WIDTH(24), .TLAST_MODE(0)) u_a (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_a), .done(done_a),
    .frame_count(fc_a), .mem_rd_en(re_a), .mem_addr(addr_a), .mem_rd_data(rd_a),
    .m_axis(if_a)
  );

  axis_frame_source #(.WIDTH(4), .HEIGHT(2), .DATA_WIDTH(24), .TLAST_MODE(1)) u_b (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_b), .done(done_b),
    .frame_count(fc_b), .mem_rd_en(re_b), .mem_addr(addr_b), .mem_rd_data(rd_b),
    .m_axis(if_b)
  );

  axis_frame_source #(.WIDTH(128), .HEIGHT(100), .DATA_WIDTH(24), .TLAST_MODE(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .frame_count(fc_c), .mem_rd_en(re_c), .mem_addr(addr_c), .mem_rd_data(rd_c),
    .m_axis(if_c)
  );

  // Frame-buffer models: mem[i] = i, data one cycle after the read strobe.
  always @(posedge clk) begin
    if (re_a) rd_a <= 24'(addr_a);
    if (re_b) rd_b <= 24'(addr_b);
    if (re_c) rd_c <= 24'(addr_c);
  end

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    end
  endtask

  function automatic void push_frame(input int d, input int w, input int h, input bit eol);
    exp_t e;
    for (int i = 0; i < w * h; i++) begin
      e.data = 24'(i);
      e.user = (i == 0);
      e.last = eol ? ((i % w) == (w - 1)) : (i == (w * h - 1));
      e.eof  = (i == (w * h - 1));
      exp_q[d].push_back(e);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_small();
    step();
    start_s = 1'b1;
    push_frame(0, 4, 2, 1'b0);
    push_frame(1, 4, 2, 1'b1);
    step();
    start_s = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    bit seen = 1'b0;
    logic [2:0] dv;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      dv   = {done_c, done_b, done_a};
      seen = dv[d];
      step();
    end
    check("done_seen", d, 32'(seen), 32'd1);
  endtask

  // Monitor / scoreboard
  logic [2:0]  tv, tr, dn, re;
  logic [25:0] beat [3];
  int          issued [3] = '{0, 0, 0};
  int          popped [3] = '{0, 0, 0};
  logic        held_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [25:0] held_b [3];

  assign tv = {if_c.tvalid, if_b.tvalid, if_a.tvalid};
  assign tr = {if_c.tready, if_b.tready, if_a.tready};
  assign dn = {done_c, done_b, done_a};
  assign re = {re_c, re_b, re_a};
  assign beat[0] = {if_a.tdata, if_a.tuser, if_a.tlast};
  assign beat[1] = {if_b.tdata, if_b.tuser, if_b.tlast};
  assign beat[2] = {if_c.tdata, if_c.tuser, if_c.tlast};

  always @(negedge clk) begin
    logic hs;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        exp_q[d].delete();
        issued[d] = 0;
        popped[d] = 0;
        held_v[d] = 1'b0;
      end else begin
        hs = tv[d] & tr[d];
        if (held_v[d]) begin
          check("hold_valid", d, 32'(tv[d]), 32'd1);
          check("hold_beat", d, 32'(beat[d]), 32'(held_b[d]));
        end
        if (re[d]) check("rd_room", d, 32'((issued[d] - popped[d] - int'(hs)) < 2), 32'd1);
        if (hs) begin
          check("queue_nonempty", d, 32'(exp_q[d].size() > 0), 32'd1);
          if (exp_q[d].size() > 0) begin
            e = exp_q[d].pop_front();
            check("tdata", d, 32'(beat[d][25:2]), 32'(e.data));
            check("tuser", d, 32'(beat[d][1]), 32'(e.user));
            check("tlast", d, 32'(beat[d][0]), 32'(e.last));
            check("done", d, 32'(dn[d]), 32'(e.eof));
          end
        end else begin
          check("done_idle", d, 32'(dn[d]), 32'd0);
        end
        held_v[d] = tv[d] & ~tr[d];
        held_b[d] = beat[d];
        issued[d] += int'(re[d]);
        popped[d] += int'(hs);
      end
    end
  end

  logic [3:0] pat = 4'b1001;
  int         pat_i, stall_left;
  bit         stalled;

  initial begin
    rst      = 1'b1;
    start_s  = 1'b0;
    start_c  = 1'b0;
    tready_s = 1'b1;
    tready_c = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 0, 32'(busy_a), 32'd0);
    check("rst_done", 0, 32'(done_a), 32'd0);
    check("rst_frame_count", 0, 32'(fc_a), 32'd0);
    check("rst_mem_rd_en", 0, 32'(re_a), 32'd0);
    check("rst_mem_addr", 0, 32'(addr_a), 32'd0);
    check("rst_tvalid", 0, 32'(if_a.tvalid), 32'd0);
    check("rst_tdata", 0, 32'(if_a.tdata), 32'd0);
    check("rst_tuser", 0, 32'(if_a.tuser), 32'd0);
    check("rst_tlast", 0, 32'(if_a.tlast), 32'd0);

    // Free flow: read in cycle 1, first beat in cycle 3, last beat and done in cycle 10
    start_small();
    @(negedge clk);
    check("lat_rd_en", 0, 32'(re_a), 32'd1);
    check("lat_addr", 0, 32'(addr_a), 32'd0);
    check("lat_busy", 0, 32'(busy_a), 32'd1);
    check("lat_tvalid_c1", 0, 32'(if_a.tvalid), 32'd0);
    step();
    @(negedge clk);
    check("lat_tvalid_c2", 0, 32'(if_a.tvalid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      @(negedge clk);
      check("stream_valid", 0, 32'(if_a.tvalid), 32'd1);
      check("stream_done", 0, 32'(done_a), 32'(k == 7));
    end
    step();
    @(negedge clk);
    check("end_busy", 0, 32'(busy_a), 32'd0);
    check("end_tvalid", 0, 32'(if_a.tvalid), 32'd0);
    check("frame_count_1", 0, 32'(fc_a), 32'd1);
    check("frame_count_1", 1, 32'(fc_b), 32'd1);

    // Backpressure: ready 1,0,0,1 repeating, plus a 5-cycle stall on pixel 4
    start_small();
    pat_i      = 0;
    stall_left = 0;
    stalled    = 1'b0;
    got        = 1'b0;
    for (int c = 0; c < 120 && !got; c++) begin
      if (stall_left > 0) begin
        tready_s = 1'b0;
        stall_left--;
      end else if (!stalled && if_a.tvalid && (if_a.tdata == 24'd4)) begin
        stalled    = 1'b1;
        stall_left = 4;
        tready_s   = 1'b0;
      end else begin
        tready_s = pat[pat_i % 4];
        pat_i++;
      end
      @(negedge clk);
      got = done_a;
      step();
    end
    check("bp_done_seen", 0, 32'(got), 32'd1);
    tready_s = 1'b1;
    @(negedge clk);
    check("frame_count_2", 0, 32'(fc_a), 32'd2);
    check("frame_count_2", 1, 32'(fc_b), 32'd2);

    // start during RUN is ignored; start the cycle after done is accepted
    step();
    start_s = 1'b1;
    push_frame(0, 4, 2, 1'b0);
    push_frame(1, 4, 2, 1'b1);
    step(); start_s = 1'b0;
    repeat (3) step();
    start_s = 1'b1;
    step(); start_s = 1'b0;
    step(); start_s = 1'b1;
    step(); start_s = 1'b0;
    @(negedge clk);
    check("ign_busy", 0, 32'(busy_a), 32'd1);
    repeat (3) step();
    @(negedge clk);
    check("ign_done_c10", 0, 32'(done_a), 32'd1);
    step();
    start_s = 1'b1;
    push_frame(0, 4, 2, 1'b0);
    push_frame(1, 4, 2, 1'b1);
    @(negedge clk);
    check("frame_count_3", 0, 32'(fc_a), 32'd3);
    check("frame_count_3", 1, 32'(fc_b), 32'd3);
    check("idle_after_done", 0, 32'(busy_a), 32'd0);
    step();
    start_s = 1'b0;
    wait_done(0, 40);
    @(negedge clk);
    check("frame_count_4", 0, 32'(fc_a), 32'd4);
    check("frame_count_4", 1, 32'(fc_b), 32'd4);

    // Reset right after the pixel-2 handshake, then a clean frame
    start_small();
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = if_a.tvalid && if_a.tready && (if_a.tdata == 24'd2);
      step();
    end
    check("px2_seen", 0, 32'(got), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_tvalid", 0, 32'(if_a.tvalid), 32'd0);
    check("abort_busy", 0, 32'(busy_a), 32'd0);
    check("abort_frame_count", 0, 32'(fc_a), 32'd0);
    check("abort_tvalid", 1, 32'(if_b.tvalid), 32'd0);
    check("abort_frame_count", 1, 32'(fc_b), 32'd0);
    start_small();
    wait_done(0, 40);
    @(negedge clk);
    check("post_abort_frame_count", 0, 32'(fc_a), 32'd1);
    check("post_abort_frame_count", 1, 32'(fc_b), 32'd1);

    // Full 128x100 frame with random ready
    step();
    start_c = 1'b1;
    push_frame(2, 128, 100, 1'b0);
    step();
    start_c = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 60000 && !got; c++) begin
      tready_c = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      got = done_c;
      step();
    end
    check("big_done_seen", 2, 32'(got), 32'd1);
    tready_c = 1'b1;
    @(negedge clk);
    check("big_frame_count", 2, 32'(fc_c), 32'd1);
    check("big_busy_end", 2, 32'(busy_c), 32'd0);

    for (int d = 0; d < 3; d++) check("queue_drained", d, 32'(exp_q[d].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
